semaforo_monitor: RTL and testbench

- Passive checker at the consumer end of the semaforo light interface: samples clk/rst/bt and the two 3-bit light buses A and B exactly as the semaforo drives them.
- Verifies encoding, mutual exclusion, colour sequence, dwell times and button service.
- Reports sticky error flags, the first error code, and cycle statistics.
- Instantiated beside semaforo in system benches and in the FPGA top level to drive an error LED.

---
 rtl/semaforo_monitor_pkg.sv | 56 +++++
 rtl/semaforo_monitor_if.sv | 9 +
 rtl/semaforo_dwell_check.sv | 63 ++++++
 rtl/semaforo_monitor.sv | 177 +++++++++++++++++
 tb/tb_semaforo_monitor.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/semaforo_monitor_pkg.sv
// Shared definitions for the semaforo light monitor: colour codes, error codes,
// flag positions, default timing and small combinational helpers.
package semaforo_monitor_pkg;

  localparam logic [2:0] COR_VERDE    = 3'b100;
  localparam logic [2:0] COR_AMARELO  = 3'b010;
  localparam logic [2:0] COR_VERMELHO = 3'b001;

  localparam logic [7:0] DEF_VERDE    = 8'd1;
  localparam logic [7:0] DEF_AMARELO  = 8'd3;
  localparam logic [7:0] DEF_VERMELHO = 8'd2;
  localparam logic [7:0] DEF_BT_LAT   = 8'd4;

  localparam int unsigned FLAG_ENC      = 0;
  localparam int unsigned FLAG_CONFLICT = 1;
  localparam int unsigned FLAG_SEQ      = 2;
  localparam int unsigned FLAG_TIME     = 3;
  localparam int unsigned FLAG_BT       = 4;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_ENC      = 3'd1,
    ERR_CONFLICT = 3'd2,
    ERR_SEQ      = 3'd3,
    ERR_TIME     = 3'd4,
    ERR_BT       = 3'd5
  } err_code_t;

  function automatic logic is_onehot3(input logic [2:0] v);
    case (v)
      COR_VERDE, COR_AMARELO, COR_VERMELHO: return 1'b1;
      default:                              return 1'b0;
    endcase
  endfunction

  function automatic logic legal_next(input logic [2:0] from_c, input logic [2:0] to_c);
    return ((from_c == COR_VERDE)    && (to_c == COR_AMARELO)) ||
           ((from_c == COR_AMARELO)  && (to_c == COR_VERMELHO)) ||
           ((from_c == COR_VERMELHO) && (to_c == COR_VERDE));
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Lowest code wins when several errors land in the same sample.
  function automatic err_code_t first_code(input logic [4:0] f);
    if (f[FLAG_ENC])           return ERR_ENC;
    else if (f[FLAG_CONFLICT]) return ERR_CONFLICT;
    else if (f[FLAG_SEQ])      return ERR_SEQ;
    else if (f[FLAG_TIME])     return ERR_TIME;
    else if (f[FLAG_BT])       return ERR_BT;
    else                       return ERR_NONE;
  endfunction

endpackage

// File: rtl/semaforo_monitor_if.sv
// Light bus between semaforo (master) and its consumers such as the monitor (slave).
interface semaforo_monitor_if;
  logic       bt;
  logic [2:0] A;
  logic [2:0] B;

  modport master (output bt, A, B);
  modport slave  (input  bt, A, B);
endinterface

// File: rtl/semaforo_dwell_check.sv
// Dwell counter for one light plus the TIME comparisons made against the count
// that was held before the current sample.
module semaforo_dwell_check
  import semaforo_monitor_pkg::*;
#(
  parameter logic [7:0] VERDE    = DEF_VERDE,
  parameter logic [7:0] AMARELO  = DEF_AMARELO,
  parameter logic [7:0] VERMELHO = DEF_VERMELHO
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_s,
  input  logic       hist_s,
  input  logic [2:0] cur_s,
  input  logic [2:0] prev_s,
  output logic [7:0] dwell_r,
  output logic       time_err_s
);

  logic       trans_s;
  logic [8:0] next_cnt_s;

  // Transition detect and the dwell value this sample would produce when staying
  always_comb begin
    trans_s    = sample_s && hist_s && (cur_s != prev_s);
    next_cnt_s = {1'b0, dwell_r} + 9'd1;
  end

  // Leaving a colour checks the finished dwell; staying flags an overstay at once
  always_comb begin
    time_err_s = 1'b0;
    if (sample_s && hist_s) begin
      if (trans_s) begin
        case (prev_s)
          COR_VERDE:    time_err_s = (dwell_r < VERDE);
          COR_AMARELO:  time_err_s = (dwell_r != AMARELO);
          COR_VERMELHO: time_err_s = (dwell_r != VERMELHO);
          default:      time_err_s = 1'b0;
        endcase
      end else begin
        case (cur_s)
          COR_AMARELO:  time_err_s = (next_cnt_s > {1'b0, AMARELO});
          COR_VERMELHO: time_err_s = (next_cnt_s > {1'b0, VERMELHO});
          default:      time_err_s = 1'b0;
        endcase
      end
    end else begin
      time_err_s = 1'b0;
    end
  end

  // Invalid codes freeze the count; a new colour or the first sample restarts at 1
  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_r <= 8'd0;
    end else if (sample_s) begin
      dwell_r <= (!hist_s || trans_s) ? 8'd1 : sat_inc8(dwell_r);
    end else begin
      dwell_r <= dwell_r;
    end
  end

endmodule

// File: rtl/semaforo_monitor.sv
// Passive checker on the semaforo light bus: encoding, mutual exclusion, colour
// order, dwell times and pedestrian button service, with sticky error reporting.
module semaforo_monitor
  import semaforo_monitor_pkg::*;
#(
  parameter logic [7:0] VERDE    = DEF_VERDE,
  parameter logic [7:0] AMARELO  = DEF_AMARELO,
  parameter logic [7:0] VERMELHO = DEF_VERMELHO,
  parameter logic [7:0] BT_LAT   = DEF_BT_LAT
) (
  input  logic                clk,
  input  logic                rst,
  semaforo_monitor_if.slave   lights,
  output logic                err,
  output logic [4:0]          err_flags,
  output logic [2:0]          err_code,
  output logic [7:0]          a_rounds,
  output logic [7:0]          dwell
);

  logic [2:0] prev_a_r, prev_b_r;
  logic       a_hist_r, b_hist_r;
  logic       a_glitch_r, b_glitch_r;
  logic       seen_gy_r, seen_yr_r;
  logic [7:0] rounds_r;
  logic       bt_armed_r;
  logic [7:0] bt_timer_r;
  logic [4:0] flags_r;
  logic       err_r;
  err_code_t  code_r;

  logic       enc_a_ok_s, enc_b_ok_s;
  logic       a_trans_s, b_trans_s;
  logic       seq_a_s, seq_b_s;
  logic       a_green_s, bt_hit_s;
  logic       time_err_a_s;
  logic [7:0] dwell_a_s;
  logic [4:0] new_flags_s;

  semaforo_dwell_check #(
    .VERDE   (VERDE),
    .AMARELO (AMARELO),
    .VERMELHO(VERMELHO)
  ) u_dwell_a (
    .clk       (clk),
    .rst       (rst),
    .sample_s  (enc_a_ok_s),
    .hist_s    (a_hist_r),
    .cur_s     (lights.A),
    .prev_s    (prev_a_r),
    .dwell_r   (dwell_a_s),
    .time_err_s(time_err_a_s)
  );

  // Per-sample error detection; a return to the same colour across a bad code is a SEQ error
  always_comb begin
    enc_a_ok_s = is_onehot3(lights.A);
    enc_b_ok_s = is_onehot3(lights.B);
    a_trans_s  = enc_a_ok_s && a_hist_r && (lights.A != prev_a_r);
    b_trans_s  = enc_b_ok_s && b_hist_r && (lights.B != prev_b_r);
    seq_a_s    = enc_a_ok_s && a_hist_r &&
                 (a_trans_s ? !legal_next(prev_a_r, lights.A) : a_glitch_r);
    seq_b_s    = enc_b_ok_s && b_hist_r &&
                 (b_trans_s ? !legal_next(prev_b_r, lights.B) : b_glitch_r);
    a_green_s  = enc_a_ok_s && (lights.A == COR_VERDE);
    bt_hit_s   = bt_armed_r && a_green_s && (bt_timer_r >= BT_LAT);

    new_flags_s                = 5'b00000;
    new_flags_s[FLAG_ENC]      = !enc_a_ok_s || !enc_b_ok_s;
    new_flags_s[FLAG_CONFLICT] = (lights.A != COR_VERMELHO) && (lights.B != COR_VERMELHO);
    new_flags_s[FLAG_SEQ]      = seq_a_s || seq_b_s;
    new_flags_s[FLAG_TIME]     = time_err_a_s;
    new_flags_s[FLAG_BT]       = bt_hit_s;
  end

  // Last valid colour per light; invalid samples leave history untouched but mark a glitch
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_a_r   <= 3'b000;
      prev_b_r   <= 3'b000;
      a_hist_r   <= 1'b0;
      b_hist_r   <= 1'b0;
      a_glitch_r <= 1'b0;
      b_glitch_r <= 1'b0;
    end else begin
      if (enc_a_ok_s) begin
        prev_a_r   <= lights.A;
        a_hist_r   <= 1'b1;
        a_glitch_r <= 1'b0;
      end else begin
        prev_a_r   <= prev_a_r;
        a_hist_r   <= a_hist_r;
        a_glitch_r <= a_hist_r;
      end
      if (enc_b_ok_s) begin
        prev_b_r   <= lights.B;
        b_hist_r   <= 1'b1;
        b_glitch_r <= 1'b0;
      end else begin
        prev_b_r   <= prev_b_r;
        b_hist_r   <= b_hist_r;
        b_glitch_r <= b_hist_r;
      end
    end
  end

  // Round counting: R->G only counts once both G->Y and Y->R have been seen
  always_ff @(posedge clk) begin
    if (rst) begin
      seen_gy_r <= 1'b0;
      seen_yr_r <= 1'b0;
      rounds_r  <= 8'd0;
    end else if (a_trans_s) begin
      case ({prev_a_r, lights.A})
        {COR_VERDE, COR_AMARELO}:   seen_gy_r <= 1'b1;
        {COR_AMARELO, COR_VERMELHO}: seen_yr_r <= 1'b1;
        {COR_VERMELHO, COR_VERDE}: begin
          if (seen_gy_r && seen_yr_r) begin
            rounds_r  <= rounds_r + 8'd1;
            seen_gy_r <= 1'b0;
            seen_yr_r <= 1'b0;
          end else begin
            rounds_r  <= rounds_r;
          end
        end
        default: rounds_r <= rounds_r;
      endcase
    end else begin
      rounds_r <= rounds_r;
    end
  end

  // Button service timer, armed only by a press sampled during A green
  always_ff @(posedge clk) begin
    if (rst) begin
      bt_armed_r <= 1'b0;
      bt_timer_r <= 8'd0;
    end else if (!bt_armed_r) begin
      if (a_hist_r && a_green_s && lights.bt) begin
        bt_armed_r <= 1'b1;
        bt_timer_r <= 8'd0;
      end else begin
        bt_armed_r <= 1'b0;
      end
    end else if (enc_a_ok_s && !a_green_s) begin
      bt_armed_r <= 1'b0;
    end else if (bt_hit_s) begin
      bt_armed_r <= 1'b0;
    end else begin
      bt_timer_r <= sat_inc8(bt_timer_r);
    end
  end

  // Sticky flags; the first error code is captured once and held until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_r <= 5'b00000;
      err_r   <= 1'b0;
      code_r  <= ERR_NONE;
    end else begin
      flags_r <= flags_r | new_flags_s;
      err_r   <= |(flags_r | new_flags_s);
      if (code_r == ERR_NONE) begin
        code_r <= first_code(new_flags_s);
      end else begin
        code_r <= code_r;
      end
    end
  end

  assign err       = err_r;
  assign err_flags = flags_r;
  assign err_code  = code_r;
  assign a_rounds  = rounds_r;
  assign dwell     = dwell_a_s;

endmodule

// File: tb/tb_semaforo_monitor.sv
// Directed-vector bench for semaforo_monitor: the driver queues hand-computed
// expectations, the monitor pops one per sampled cycle and compares.
module tb_semaforo_monitor;
  import semaforo_monitor_pkg::*;

  localparam logic [2:0] G   = 3'b100;
  localparam logic [2:0] Y   = 3'b010;
  localparam logic [2:0] R   = 3'b001;
  localparam logic [2:0] BAD = 3'b110;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       err;
  logic [4:0] err_flags;
  logic [2:0] err_code;
  logic [7:0] a_rounds;
  logic [7:0] dwell;

  semaforo_monitor_if lif();

  semaforo_monitor #(
    .VERDE   (8'd1),
    .AMARELO (8'd3),
    .VERMELHO(8'd2),
    .BT_LAT  (8'd4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .lights   (lif.slave),
    .err      (err),
    .err_flags(err_flags),
    .err_code (err_code),
    .a_rounds (a_rounds),
    .dwell    (dwell)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [4:0] flags;
    logic [2:0] code;
    logic [7:0] rounds;
    logic [7:0] dwell;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_n  = 0;

  task automatic chk(input string what, input int idx, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s vec %0d: got %0h, want %0h", what, idx, act, req);
    end
  endtask

  task automatic step(input logic r, input logic b_t, input logic [2:0] a, input logic [2:0] b,
                      input logic [4:0] f, input logic [2:0] c, input logic [7:0] rn,
                      input logic [7:0] d);
    exp_t e;
    @(negedge clk);
    rst    = r;
    lif.bt = b_t;
    lif.A  = a;
    lif.B  = b;
    e.idx    = vec_n;
    e.flags  = f;
    e.code   = c;
    e.rounds = rn;
    e.dwell  = d;
    exp_q.push_back(e);
    vec_n++;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("err_flags", e.idx, {3'b000, err_flags}, {3'b000, e.flags});
        chk("err",       e.idx, {7'd0, err},         {7'd0, |e.flags});
        chk("err_code",  e.idx, {5'd0, err_code},    {5'd0, e.code});
        chk("a_rounds",  e.idx, a_rounds,            e.rounds);
        chk("dwell",     e.idx, dwell,               e.dwell);
      end
    end
  end

  initial begin : driver
    rst    = 1'b1;
    lif.bt = 1'b0;
    lif.A  = R;
    lif.B  = R;

    // legal run: two full rounds, dwell restarts at 1 on each transition
    step(1'b1, 1'b0, R, R, 5'b00000, 3'd0, 8'd0, 8'd0);
    step(1'b0, 1'b0, G, R, 5'b00000, 3'd0, 8'd0, 8'd1);
    step(1'b0, 1'b0, Y, R, 5'b00000, 3'd0, 8'd0, 8'd1);
    step(1'b0, 1'b0, Y, R, 5'b00000, 3'd0, 8'd0, 8'd2);
    step(1'b0, 1'b0, Y, R, 5'b00000, 3'd0, 8'd0, 8'd3);
    step(1'b0, 1'b0, R, R, 5'b00000, 3'd0, 8'd0, 8'd1);
    step(1'b0, 1'b0, R, R, 5'b00000, 3'd0, 8'd0, 8'd2);
    step(1'b0, 1'b0, G, R, 5'b00000, 3'd0, 8'd1, 8'd1);
    step(1'b0, 1'b0, Y, R, 5'b00000, 3'd0, 8'd1, 8'd1);
    step(1'b0, 1'b0, Y, R, 5'b00000, 3'd0, 8'd1, 8'd2);
    step(1'b0, 1'b0, Y, R, 5'b00000, 3'd0, 8'd1, 8'd3);
    step(1'b0, 1'b0, R, R, 5'b00000, 3'd0, 8'd1, 8'd1);
    step(1'b0, 1'b0, R, R, 5'b00000, 3'd0, 8'd1, 8'd2);
    step(1'b0, 1'b0, G, R, 5'b00000, 3'd0, 8'd2, 8'd1);

    // invalid A code: ENC only, dwell frozen; later a glitch back into yellow is SEQ
    step(1'b1, 1'b0, R,   R, 5'b00000, 3'd0, 8'd0, 8'd0);
    step(1'b0, 1'b0, G,   R, 5'b00000, 3'd0, 8'd0, 8'd1);
    step(1'b0, 1'b0, G,   R, 5'b00000, 3'd0, 8'd0, 8'd2);
    step(1'b0, 1'b0, G,   R, 5'b00000, 3'd0, 8'd0, 8'd3);
    step(1'b0, 1'b0, G,   R, 5'b00000, 3'd0, 8'd0, 8'd4);
    step(1'b0, 1'b0, BAD, R, 5'b00001, 3'd1, 8'd0, 8'd4);
    step(1'b0, 1'b0, Y,   R, 5'b00001, 3'd1, 8'd0, 8'd1);
    step(1'b0, 1'b0, Y,   R, 5'b00001, 3'd1, 8'd0, 8'd2);
    step(1'b0, 1'b0, BAD, R, 5'b00001, 3'd1, 8'd0, 8'd2);
    step(1'b0, 1'b0, Y,   R, 5'b00101, 3'd1, 8'd0, 8'd3);

    // conflict first, then a short yellow adds TIME without changing the code
    step(1'b1, 1'b0, R, R, 5'b00000, 3'd0, 8'd0, 8'd0);
    step(1'b0, 1'b0, G, R, 5'b00000, 3'd0, 8'd0, 8'd1);
    step(1'b0, 1'b0, G, R, 5'b00000, 3'd0, 8'd0, 8'd2);
    step(1'b0, 1'b0, G, G, 5'b00010, 3'd2, 8'd0, 8'd3);
    step(1'b0, 1'b0, Y, Y, 5'b00010, 3'd2, 8'd0, 8'd1);
    step(1'b0, 1'b0, Y, R, 5'b00010, 3'd2, 8'd0, 8'd2);
    step(1'b0, 1'b0, R, R, 5'b01010, 3'd2, 8'd0, 8'd1);

    // G->R skip is SEQ; yellow overstay flags on its 4th sample; no round credited
    step(1'b1, 1'b0, R, R, 5'b00000, 3'd0, 8'd0, 8'd0);
    step(1'b0, 1'b0, G, R, 5'b00000, 3'd0, 8'd0, 8'd1);
    step(1'b0, 1'b0, R, R, 5'b00100, 3'd3, 8'd0, 8'd1);
    step(1'b0, 1'b0, R, R, 5'b00100, 3'd3, 8'd0, 8'd2);
    step(1'b0, 1'b0, G, R, 5'b00100, 3'd3, 8'd0, 8'd1);
    step(1'b0, 1'b0, Y, R, 5'b00100, 3'd3, 8'd0, 8'd1);
    step(1'b0, 1'b0, Y, R, 5'b00100, 3'd3, 8'd0, 8'd2);
    step(1'b0, 1'b0, Y, R, 5'b00100, 3'd3, 8'd0, 8'd3);
    step(1'b0, 1'b0, Y, R, 5'b01100, 3'd3, 8'd0, 8'd4);

    // button pressed in green, green held past the latency; re-press does not restart
    step(1'b1, 1'b0, R, R, 5'b00000, 3'd0, 8'd0, 8'd0);
    step(1'b0, 1'b0, G, R, 5'b00000, 3'd0, 8'd0, 8'd1);
    step(1'b0, 1'b1, G, R, 5'b00000, 3'd0, 8'd0, 8'd2);
    step(1'b0, 1'b0, G, R, 5'b00000, 3'd0, 8'd0, 8'd3);
    step(1'b0, 1'b1, G, R, 5'b00000, 3'd0, 8'd0, 8'd4);
    step(1'b0, 1'b0, G, R, 5'b00000, 3'd0, 8'd0, 8'd5);
    step(1'b0, 1'b0, G, R, 5'b00000, 3'd0, 8'd0, 8'd6);
    step(1'b0, 1'b0, G, R, 5'b10000, 3'd5, 8'd0, 8'd7);

    // same press, green left at timer 3: no BT; press in yellow ignored
    step(1'b1, 1'b0, R, R, 5'b00000, 3'd0, 8'd0, 8'd0);
    step(1'b0, 1'b0, G, R, 5'b00000, 3'd0, 8'd0, 8'd1);
    step(1'b0, 1'b1, G, R, 5'b00000, 3'd0, 8'd0, 8'd2);
    step(1'b0, 1'b0, G, R, 5'b00000, 3'd0, 8'd0, 8'd3);
    step(1'b0, 1'b0, G, R, 5'b00000, 3'd0, 8'd0, 8'd4);
    step(1'b0, 1'b0, G, R, 5'b00000, 3'd0, 8'd0, 8'd5);
    step(1'b0, 1'b0, Y, R, 5'b00000, 3'd0, 8'd0, 8'd1);
    step(1'b0, 1'b1, Y, R, 5'b00000, 3'd0, 8'd0, 8'd2);
    step(1'b0, 1'b0, Y, R, 5'b00000, 3'd0, 8'd0, 8'd3);
    step(1'b0, 1'b0, R, R, 5'b00000, 3'd0, 8'd0, 8'd1);
    step(1'b0, 1'b0, R, R, 5'b00000, 3'd0, 8'd0, 8'd2);
    step(1'b0, 1'b0, G, R, 5'b00000, 3'd0, 8'd1, 8'd1);
    step(1'b0, 1'b0, G, R, 5'b00000, 3'd0, 8'd1, 8'd2);

    // TIME error, reset during yellow, then a clean sequence from scratch
    step(1'b1, 1'b0, R, R, 5'b00000, 3'd0, 8'd0, 8'd0);
    step(1'b0, 1'b0, G, R, 5'b00000, 3'd0, 8'd0, 8'd1);
    step(1'b0, 1'b0, Y, R, 5'b00000, 3'd0, 8'd0, 8'd1);
    step(1'b0, 1'b0, R, R, 5'b01000, 3'd4, 8'd0, 8'd1);
    step(1'b0, 1'b0, R, R, 5'b01000, 3'd4, 8'd0, 8'd2);
    step(1'b0, 1'b0, G, R, 5'b01000, 3'd4, 8'd1, 8'd1);
    step(1'b0, 1'b0, Y, R, 5'b01000, 3'd4, 8'd1, 8'd1);
    step(1'b0, 1'b0, Y, R, 5'b01000, 3'd4, 8'd1, 8'd2);
    step(1'b1, 1'b0, Y, R, 5'b00000, 3'd0, 8'd0, 8'd0);
    step(1'b0, 1'b0, G, R, 5'b00000, 3'd0, 8'd0, 8'd1);
    step(1'b0, 1'b0, Y, R, 5'b00000, 3'd0, 8'd0, 8'd1);
    step(1'b0, 1'b0, Y, R, 5'b00000, 3'd0, 8'd0, 8'd2);
    step(1'b0, 1'b0, Y, R, 5'b00000, 3'd0, 8'd0, 8'd3);
    step(1'b0, 1'b0, R, R, 5'b00000, 3'd0, 8'd0, 8'd1);
    step(1'b0, 1'b0, R, R, 5'b00000, 3'd0, 8'd0, 8'd2);
    step(1'b0, 1'b0, G, R, 5'b00000, 3'd0, 8'd1, 8'd1);

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: %0d entries left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
